// File: rtl/cond_flag_if.sv
// Execute/decode-side bundle for the condition-flag unit: AU/ALU result
// capture, flag-writer issue tracking and the branch-resolution handshake.
interface cond_flag_if;
    logic        issue_flag_wr;
    logic        alu_valid;
    logic [3:0]  alu_cmd;
    logic [15:0] alu_result;
    logic        alu_v;
    logic        alu_n;
    logic        br_req;
    logic [2:0]  br_cond;
    logic        br_ack;
    logic        br_taken;
    logic [2:0]  flags;
    logic        stall;
    logic        pend_err;

    // Execute/decode side: produces results and branch requests.
    modport master (
        output issue_flag_wr, alu_valid, alu_cmd, alu_result, alu_v, alu_n,
        output br_req, br_cond,
        input  br_ack, br_taken, flags, stall, pend_err
    );

    // Flag unit side: consumes results, answers branch requests.
    modport slave (
        input  issue_flag_wr, alu_valid, alu_cmd, alu_result, alu_v, alu_n,
        input  br_req, br_cond,
        output br_ack, br_taken, flags, stall, pend_err
    );
endinterface

// File: rtl/cond_flag_unit.sv
// Architectural {Z,V,N} flag register with in-flight flag-writer tracking and
// a req/ack conditional-branch resolver that waits for all older writers.
module cond_flag_unit #(
    parameter int unsigned MAX_PENDING = 3,
    parameter int unsigned PEND_W      = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    cond_flag_if.slave bus
);

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_AND    = 4'b0001;
    localparam logic [3:0] OP_SUB    = 4'b0010;
    localparam logic [3:0] OP_NOR    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRL    = 4'b0101;
    localparam logic [3:0] OP_SRA    = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b1000;

    localparam logic [2:0] CC_NEQ    = 3'b000;
    localparam logic [2:0] CC_EQ     = 3'b001;
    localparam logic [2:0] CC_GT     = 3'b010;
    localparam logic [2:0] CC_LT     = 3'b011;
    localparam logic [2:0] CC_GTE    = 3'b100;
    localparam logic [2:0] CC_LTE    = 3'b101;
    localparam logic [2:0] CC_OVFL   = 3'b110;
    localparam logic [2:0] CC_UNCOND = 3'b111;

    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } br_state_e;

    // Flag register split so each bit can hold independently.
    logic              z_q, z_d;
    logic              v_q, v_d;
    logic              n_q, n_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              pend_err_q, pend_err_d;
    br_state_e         state_q, state_d;
    logic              br_ack_q, br_ack_d;
    logic              br_taken_q, br_taken_d;

    logic wr_zvn;
    logic wr_z_only;
    logic wr_now;
    logic clear;
    logic cond_true;

    // Classify the valid result's opcode by which flags it writes.
    always_comb begin
        wr_zvn    = 1'b0;
        wr_z_only = 1'b0;
        case (bus.alu_cmd)
            OP_ADD, OP_SUB:                     wr_zvn    = 1'b1;
            OP_PADDSB, OP_AND, OP_NOR,
            OP_SLL, OP_SRL, OP_SRA:             wr_z_only = 1'b1;
            default: begin
                wr_zvn    = 1'b0;
                wr_z_only = 1'b0;
            end
        endcase
        wr_now = bus.alu_valid & (wr_zvn | wr_z_only);
    end

    // Next flag values: Z from every writer, V/N only from ADD/SUB.
    always_comb begin
        z_d = z_q;
        v_d = v_q;
        n_d = n_q;
        if (wr_now) begin
            z_d = (bus.alu_result == 16'h0000);
            if (wr_zvn) begin
                v_d = bus.alu_v;
                n_d = bus.alu_n;
            end
        end
    end

    // In-flight writer count; saturating at both ends with a sticky error.
    always_comb begin
        pending_d  = pending_q;
        pend_err_d = pend_err_q;
        if (bus.issue_flag_wr && !wr_now) begin
            if (pending_q == PEND_MAX) begin
                pend_err_d = 1'b1;
            end else begin
                pending_d = pending_q + 1'b1;
            end
        end else if (wr_now && !bus.issue_flag_wr) begin
            if (pending_q == '0) begin
                pend_err_d = 1'b1;
            end else begin
                pending_d = pending_q - 1'b1;
            end
        end
    end

    // Branches may only resolve once no flag write is outstanding or landing.
    always_comb begin
        clear = (pending_q == '0) & ~wr_now & ~bus.issue_flag_wr;
    end

    // Condition evaluation against the retired flag register.
    always_comb begin
        cond_true = 1'b0;
        case (bus.br_cond)
            CC_NEQ:    cond_true = ~z_q;
            CC_EQ:     cond_true = z_q;
            CC_GT:     cond_true = ~z_q & ~n_q;
            CC_LT:     cond_true = n_q;
            CC_GTE:    cond_true = z_q | ~n_q;
            CC_LTE:    cond_true = z_q | n_q;
            CC_OVFL:   cond_true = v_q;
            CC_UNCOND: cond_true = 1'b1;
            default:   cond_true = 1'b0;
        endcase
    end

    // Branch FSM next state; ack is asserted on entry to RESP so it is
    // registered and lasts exactly the one RESP cycle.
    always_comb begin
        state_d    = state_q;
        br_ack_d   = 1'b0;
        br_taken_d = br_taken_q;
        case (state_q)
            IDLE: begin
                if (bus.br_req) begin
                    if (clear) begin
                        state_d    = RESP;
                        br_ack_d   = 1'b1;
                        br_taken_d = cond_true;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (clear) begin
                    state_d    = RESP;
                    br_ack_d   = 1'b1;
                    br_taken_d = cond_true;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Flag register and pending counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q        <= 1'b0;
            v_q        <= 1'b0;
            n_q        <= 1'b0;
            pending_q  <= '0;
            pend_err_q <= 1'b0;
        end else begin
            z_q        <= z_d;
            v_q        <= v_d;
            n_q        <= n_d;
            pending_q  <= pending_d;
            pend_err_q <= pend_err_d;
        end
    end

    // Branch FSM state and its registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            br_ack_q   <= 1'b0;
            br_taken_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            br_ack_q   <= br_ack_d;
            br_taken_q <= br_taken_d;
        end
    end

    assign bus.flags    = {z_q, v_q, n_q};
    assign bus.br_ack   = br_ack_q;
    assign bus.br_taken = br_taken_q;
    assign bus.pend_err = pend_err_q;
    assign bus.stall    = bus.br_req & ~br_ack_q;

endmodule

// File: doc/cond_flag_unit.md
Name: cond_flag_unit

Overview:
- Consumer end of the arithmetic-unit result interface.
- Captures the AU and logic-unit result and flags (Z, V, N) into the architectural flag register, tracking which flag writes are still in flight.
- Resolves conditional-branch requests from decode with a req/ack handshake.
- Sits between execute (AU/ALU outputs) and fetch/decode branch control. Stalls a branch until every older flag-writing op has retired.

Parameters:
- MAX_PENDING, 3, maximum number of in-flight flag-writing ops tracked.
- PEND_W, 2, width of the pending counter; must hold MAX_PENDING.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- issue_flag_wr  in  1  a flag-writing op entered execute this cycle
- alu_valid  in  1  AU/ALU result valid this cycle
- alu_cmd  in  4  opcode of the valid result
- alu_result  in  16  result word
- alu_v  in  1  overflow from AU
- alu_n  in  1  negative from AU
- br_req  in  1  branch resolution request; held until br_ack
- br_cond  in  3  condition code; stable while br_req is high
- br_ack  out  1  one-cycle resolution strobe
- br_taken  out  1  resolution result; valid when br_ack=1
- flags  out  3  {Z,V,N} architectural flags
- stall  out  1  br_req & ~br_ack (combinational)
- pend_err  out  1  sticky: pending counter overflow or underflow

Behaviour:
- Reset (async, rst_n=0): flags=3'b000, br_ack=0, br_taken=0, pend_err=0, pending=0, FSM=IDLE. A reset asserted mid-handshake aborts the branch. After reset the requester must see br_req answered from IDLE.
- Flag-writer decode on alu_cmd:
  - ADD 0000, SUB 0010: update Z, V, N.
  - PADDSB 1000, AND 0001, NOR 0011, SLL 0100, SRL 0101, SRA 0110: update Z only; V and N hold.
  - All other codes: no update, not counted as a flag writer.
- wr_now = alu_valid & flag-writer(alu_cmd).
- Flag update registered on the clk edge when wr_now=1:
  - Z = (alu_result==16'h0000).
  - V = alu_v, N = alu_n, only where the decode above permits.
- Pending counter, next value:
  - +1 on issue_flag_wr & ~wr_now.
  - -1 on wr_now & ~issue_flag_wr.
  - Unchanged when both or neither are asserted.
  - Increment at MAX_PENDING: saturate and set pend_err.
  - Decrement at 0: hold 0 and set pend_err; the flags still update.
- clear = (pending==0) & ~wr_now & ~issue_flag_wr.
- Condition evaluation, using the registered flags:
  - 000 NEQ: ~Z
  - 001 EQ: Z
  - 010 GT: ~Z & ~N
  - 011 LT: N
  - 100 GTE: Z | ~N
  - 101 LTE: Z | N
  - 110 OVFL: V
  - 111 UNCOND: 1
- Branch FSM:
  - IDLE: on br_req, go to RESP if clear, else WAIT. br_taken is latched from the evaluation at the transition.
  - WAIT: go to RESP when clear, latching br_taken; otherwise stay.
  - RESP: br_ack=1 for exactly one cycle, then IDLE.
  - br_req sampled high in IDLE the cycle after an ack starts a new resolution.
- Latency: minimum 1 cycle from br_req to br_ack. Otherwise, 1 cycle after the last pending flag write retires.
- A flag write and a branch evaluation never occur in the same cycle, because clear requires ~wr_now. Evaluation therefore always sees the retired flags.
- br_ack and br_taken are registered. br_taken holds its value outside ack cycles. flags is driven directly from the register.

Test Plan:
- Reset then ADD with alu_result=0, alu_v=0, alu_n=0 → flags=3'b100; br_req cond=001 → br_ack 1 cycle later, br_taken=1.
- SUB with alu_result=16'h8000, alu_v=1, alu_n=1, followed by AND with alu_result=16'h0001 → flags={0,1,1}; cond=110 gives taken=1; cond=010 gives taken=0.
- issue_flag_wr pulses twice, then br_req cond=000 → stall=1 and no ack until the second wr_now retires; ack exactly 1 cycle after it; taken reflects the last result's Z.
- issue_flag_wr and wr_now in the same cycle with pending=1 → pending stays 1, branch remains in WAIT; a later wr_now releases it.
- Four issue_flag_wr with no retire → pending saturates at 3, pend_err=1 (sticky). Separately, alu_valid ADD with pending=0 → flags update, pend_err=1.
- rst_n low while in WAIT → br_ack=0, flags=0 immediately. After release, br_req cond=111 → br_ack next cycle, br_taken=1.
